// File: rtl/mmp_iddmm_finalsub.sv
// IDDMM final-subtraction responder: compare pass over A/M, then an output pass emitting A-M or A.
// Optional MMP_FINALSUB_CT_EN forces both passes regardless of ref_an (constant latency 2N+4).
module mmp_iddmm_finalsub #(
  parameter int N      = 32,
  parameter int K      = 128,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              comp_req,
  input  logic              ref_an,
  output logic              comp_end,
  output logic              busy,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ena,
  input  logic [K-1:0]      rd_a_data,
  input  logic [K-1:0]      rd_m_data,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [K-1:0]      out_data,
  output logic              out_sel
);

  typedef enum logic [2:0] {IDLE, CMP, DEC, OUT, DONE} state_t;

  localparam logic [ADDR_W:0] CNT_N = (ADDR_W+1)'(N);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                an_q, an_d;
  logic                borrow_q, borrow_d;
  logic                sel_q, sel_d;
  logic                req_q;
  logic                rd_ena_q, rd_ena_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                ov_q, ov_d;
  logic [ADDR_W-1:0]   oaddr_q, oaddr_d;
  logic                start;
  logic [K:0]          diff;

  // Rising edge of the level request only; a request held past comp_end never restarts.
  assign start = (state_q == IDLE) && comp_req && !req_q;
  assign diff  = {1'b0, rd_a_data} - {1'b0, rd_m_data} - {{K{1'b0}}, borrow_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      an_q      <= 1'b0;
      borrow_q  <= 1'b0;
      sel_q     <= 1'b0;
      req_q     <= 1'b0;
      rd_ena_q  <= 1'b0;
      rd_addr_q <= '0;
      ov_q      <= 1'b0;
      oaddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      an_q      <= an_d;
      borrow_q  <= borrow_d;
      sel_q     <= sel_d;
      req_q     <= comp_req;
      rd_ena_q  <= rd_ena_d;
      rd_addr_q <= rd_addr_d;
      ov_q      <= ov_d;
      oaddr_q   <= oaddr_d;
    end
  end

  // cnt runs 0..N in both passes: reads issue at 0..N-1, data lands at 1..N.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        cnt_d = '0;
`ifdef MMP_FINALSUB_CT_EN
        state_d = CMP;
`else
        state_d = ref_an ? DEC : CMP;
`endif
      end
      CMP, OUT: begin
        if (cnt_q == CNT_N) state_d = (state_q == CMP) ? DEC : DONE;
        else                cnt_d   = cnt_q + 1'b1;
      end
      DEC: begin
        state_d = OUT;
        cnt_d   = '0;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    an_d     = an_q;
    borrow_d = borrow_q;
    sel_d    = sel_q;
    case (state_q)
      IDLE: if (start) begin
        an_d     = ref_an;
        borrow_d = 1'b0;
      end
      CMP: if (cnt_q != '0) borrow_d = diff[K];
      DEC: begin
        sel_d    = an_q | ~borrow_q;
        borrow_d = 1'b0;
      end
      OUT: if (ov_q && sel_q) borrow_d = diff[K];
      default: ;
    endcase
    rd_ena_d  = ((state_d == CMP) || (state_d == OUT)) && (cnt_d != CNT_N);
    rd_addr_d = rd_ena_d ? cnt_d[ADDR_W-1:0] : rd_addr_q;
    ov_d      = (state_d == OUT) && (cnt_d != '0);
    oaddr_d   = ov_d ? ADDR_W'(cnt_d - 1'b1) : oaddr_q;
  end

  assign comp_end  = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rd_ena    = rd_ena_q;
  assign rd_addr   = rd_addr_q;
  assign out_valid = ov_q;
  assign out_addr  = oaddr_q;
  assign out_sel   = sel_q;
  // RAM data arrives combinationally in the strobe cycle, so the result word is formed here.
  assign out_data  = ov_q ? (sel_q ? diff[K-1:0] : rd_a_data) : '0;

endmodule

// File: tb/tb_mmp_iddmm_finalsub.sv
// Bench for mmp_iddmm_finalsub at N=4, K=8: scoreboard of expected result words from a 32-bit model.
module tb_mmp_iddmm_finalsub;
  localparam int N  = 4;
  localparam int K  = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst, comp_req, ref_an;
  logic          comp_end, busy, rd_ena, out_valid, out_sel;
  logic [AW-1:0] rd_addr, out_addr;
  logic [K-1:0]  rd_a_data, rd_m_data, out_data;
  logic [K-1:0]  a_mem [N];
  logic [K-1:0]  m_mem [N];
  logic [K-1:0]  exp_q [$];
  int            n_checks = 0;
  int            n_fail   = 0;

  always #5 clk = ~clk;

  mmp_iddmm_finalsub #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst), .comp_req(comp_req), .ref_an(ref_an),
    .comp_end(comp_end), .busy(busy), .rd_addr(rd_addr), .rd_ena(rd_ena),
    .rd_a_data(rd_a_data), .rd_m_data(rd_m_data), .out_valid(out_valid),
    .out_addr(out_addr), .out_data(out_data), .out_sel(out_sel)
  );

  always @(posedge clk) begin
    if (rd_ena) begin
      rd_a_data <= a_mem[rd_addr];
      rd_m_data <= m_mem[rd_addr];
    end
  end

  task automatic load(input logic [31:0] a, input logic [31:0] m);
    for (int i = 0; i < N; i++) begin
      a_mem[i] = a[8*i +: 8];
      m_mem[i] = m[8*i +: 8];
    end
  endtask

  // Drives one request and scores every strobe against the model; comp_req drops hold cycles after comp_end.
  task automatic run_op(input string name, input logic an, input logic [31:0] a, input logic [31:0] m,
                        input int exp_end, input int exp_rd, input int hold);
    logic [31:0] r;
    logic        sel;
    logic [7:0]  w;
    int          end_c = 0, ends = 0, rds = 0, idx = 0;
    sel = an || (a >= m);
    r   = sel ? a - m : a;
    load(a, m);
    for (int i = 0; i < N; i++) exp_q.push_back(r[8*i +: 8]);
    @(negedge clk);
    ref_an   = an;
    comp_req = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (rd_ena) rds++;
      if (c == 1) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_c1 got %b want 1", name, busy); end
      end
      if (out_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL %s extra_word got %h at addr %0d want none", name, out_data, out_addr);
        end else begin
          w = exp_q.pop_front();
          if (out_data !== w || out_addr !== AW'(idx) || out_sel !== sel) begin
            n_fail++;
            $display("FAIL %s word%0d got data=%h addr=%0d sel=%b want data=%h addr=%0d sel=%b",
                     name, idx, out_data, out_addr, out_sel, w, idx, sel);
          end
          idx++;
        end
      end
      if (comp_end) begin
        ends++;
        if (end_c == 0) end_c = c;
      end
      if (end_c != 0 && c == end_c + 1) begin
        n_checks++;
        if (busy !== 1'b0 || out_sel !== sel || rd_addr !== AW'(N-1)) begin
          n_fail++;
          $display("FAIL %s post_done got busy=%b sel=%b rd_addr=%0d want 0 %b %0d", name, busy, out_sel, rd_addr, sel, N-1);
        end
      end
      if (end_c != 0 && c == end_c + hold) comp_req = 1'b0;
      if (end_c != 0 && c >= end_c + hold + 3) break;
    end
    comp_req = 1'b0;
    n_checks++;
    if (end_c != exp_end) begin n_fail++; $display("FAIL %s comp_end_cycle got %0d want %0d", name, end_c, exp_end); end
    n_checks++;
    if (ends != 1) begin n_fail++; $display("FAIL %s comp_end_count got %0d want 1", name, ends); end
    n_checks++;
    if (rds != exp_rd) begin n_fail++; $display("FAIL %s rd_ena_cycles got %0d want %0d", name, rds, exp_rd); end
    n_checks++;
    if (idx != N) begin n_fail++; $display("FAIL %s word_count got %0d want %0d", name, idx, N); end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; comp_req = 1'b0; ref_an = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({comp_end, busy, rd_ena, out_valid, out_sel, rd_addr, out_addr, out_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got end=%b busy=%b rde=%b ov=%b sel=%b ra=%0d oa=%0d od=%h want all 0",
               comp_end, busy, rd_ena, out_valid, out_sel, rd_addr, out_addr, out_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lt();
    run_op("a_lt_m", 1'b0, 32'h8000000F, 32'h80000010, 2*N+4, 2*N, 0);
  endtask

  task automatic test_eq();
    run_op("a_eq_m", 1'b0, 32'h80000010, 32'h80000010, 2*N+4, 2*N, 0);
  endtask

  task automatic test_ripple();
    run_op("ripple", 1'b0, 32'h81000005, 32'h80000010, 2*N+4, 2*N, 0);
  endtask

  task automatic test_ref_an();
`ifdef MMP_FINALSUB_CT_EN
    run_op("ref_an", 1'b1, 32'h00000000, 32'h80000001, 2*N+4, 2*N, 0);
`else
    run_op("ref_an", 1'b1, 32'h00000000, 32'h80000001, N+3, N, 0);
`endif
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    load(32'h81000005, 32'h80000010);
    @(negedge clk);
    ref_an = 1'b0; comp_req = 1'b1;
    for (int c = 1; c <= 9; c++) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid out_valid_c9 got %b want 1", out_valid); end
    rst = 1'b1; comp_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({comp_end, busy, rd_ena, out_valid, out_sel, rd_addr, out_addr, out_data} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid outputs got end=%b busy=%b rde=%b ov=%b sel=%b ra=%0d oa=%0d od=%h want all 0",
               comp_end, busy, rd_ena, out_valid, out_sel, rd_addr, out_addr, out_data);
    end
    rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (comp_end || out_valid || rd_ena || busy) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL rst_mid quiet got %0d active cycles want 0", bad); end
    run_op("rst_rerun", 1'b0, 32'h81000005, 32'h80000010, 2*N+4, 2*N, 0);
  endtask

  task automatic test_held_req();
    run_op("held_req", 1'b0, 32'h81000005, 32'h80000010, 2*N+4, 2*N, 20);
    run_op("second_run", 1'b0, 32'h8000000F, 32'h80000010, 2*N+4, 2*N, 0);
  endtask

  initial begin
    test_reset();
    test_lt();
    test_eq();
    test_ripple();
    test_ref_an();
    test_reset_mid();
    test_held_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mmp_iddmm_finalsub.md
Name: mmp_iddmm_finalsub

Overview:
- Responder to the IDDMM controller's final-subtraction handshake (comp_req/comp_end, ref_an).
- When a Montgomery product A (N words of K bits, LSW first) is complete in the A RAM, the block computes A-M if ref_an==1 or A>=M, otherwise passes A through.
- Streams the N result words out and pulses comp_end.
- Two read passes over A and M: compare, then output. No N*K internal buffer.

Parameters:
- N, 32, number of K-bit words per operand.
- K, 128, word width in bits.
- ADDR_W, $clog2(N), RAM word-address width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- comp_req  input  1  level request from controller; held until comp_end is seen.
- ref_an  input  1  final carry of A; sampled on the start cycle.
- comp_end  output  1  one-cycle completion pulse.
- busy  output  1  high from start until the DONE cycle inclusive.
- rd_addr  output  ADDR_W  shared word address to the A and M RAMs.
- rd_ena  output  1  read enable.
- rd_a_data  input  K  A word; valid 1 cycle after rd_addr/rd_ena.
- rd_m_data  input  K  M word; valid 1 cycle after rd_addr/rd_ena.
- out_valid  output  1  result word strobe.
- out_addr  output  ADDR_W  result word index, 0..N-1.
- out_data  output  K  result word.
- out_sel  output  1  1 = A-M emitted, 0 = A emitted; valid from DEC until next start.

Behaviour:
- Reset, synchronous, takes effect regardless of state: state=IDLE; comp_end, busy, rd_ena, out_valid, out_sel = 0; rd_addr, out_addr, out_data = 0; borrow = 0; comp_req_d = 0.
- Start condition: in IDLE, comp_req && !comp_req_d, where comp_req_d is comp_req registered every cycle. A level held past comp_end never restarts the block.
- Cycle 0 = start cycle. Sample ref_an into an_r and clear borrow.
- CMP, cycles 1..N+1:
  - Cycles 1..N issue rd_addr=0..N-1 with rd_ena=1.
  - Cycles 2..N+1 update {borrow, -} = A_w - M_w - borrow, computed in K+1 bits. The difference is discarded.
- DEC, cycle N+2: out_sel <= an_r | ~borrow; clear borrow.
- OUT, cycles N+3..2N+3:
  - Cycles N+3..2N+2 issue rd_addr=0..N-1.
  - Cycles N+4..2N+3: out_valid=1, out_addr=k, out_data = out_sel ? (A_k - M_k - borrow) mod 2^K : A_k.
  - borrow is updated only when out_sel=1.
- DONE, cycle 2N+4: comp_end=1, busy=1, then return to IDLE.
- Total latency: comp_end 2N+4 cycles after the start cycle.
- rd_ena=0 and out_valid=0 outside the windows above. rd_addr holds its last value when idle.
- comp_req deasserting mid-operation is ignored; the sequence completes.
- comp_req asserting while busy is ignored.
- ref_an and the RAM contents must be stable from start until DONE; the controller guarantees this.
- Borrow out of word N-1 in OUT is discarded. The result is mod 2^(N*K).
- Counters are ADDR_W+1 bits wide so that N = 2^ADDR_W works without wrap aliasing.

Optional Feature:
- Macro MMP_FINALSUB_CT_EN.
- Defined: constant time. Both passes always run and latency is always 2N+4, independent of ref_an and data.
- Undefined: if ref_an==1 at start, CMP is skipped and the block goes IDLE -> DEC at cycle 1, with out_sel=1.
  - OUT runs cycles 2..N+2; out_valid is high on cycles 3..N+2.
  - comp_end at cycle N+3.
  - With ref_an==0, behaviour is identical to the defined case.

Test Plan:
- All scenarios use N=4, K=8; words are listed LSW first.
- 1. ref_an=0, A=[0F,00,00,80], M=[10,00,00,80] (A<M) -> out_sel=0, out=[0F,00,00,80], comp_end at cycle 12.
- 2. ref_an=0, A=M=[10,00,00,80] -> out_sel=1, out=[00,00,00,00], comp_end at cycle 12.
- 3. ref_an=0, A=[05,00,00,81], M=[10,00,00,80] -> out_sel=1, out=[F5,FF,FF,00] (borrow ripple across words), out_addr 0..3.
- 4. ref_an=1, A=[00,00,00,00], M=[01,00,00,80] -> out=[FF,FF,FF,7F].
  - Macro undefined: comp_end at cycle 7, rd_ena high 4 cycles.
  - Macro defined: comp_end at cycle 12, rd_ena high 8 cycles.
- 5. rst asserted during OUT (cycle 9) -> next cycle all outputs 0, state IDLE, no comp_end. A new comp_req rising edge with scenario 3 data then gives the scenario 3 result.
- 6. comp_req held high for 20 cycles after comp_end -> exactly one comp_end and one 4-word burst. After comp_req goes low then high, a second full run occurs.
